fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: lanes per fetch group, legal 1..8.
REQ-002 Parameter SIZE_PC, default 32: PC width in bits.
REQ-003 Parameter INST_BYTES, default 8: byte stride between lanes.
REQ-004 Port clk  in  1: single clock; all state on posedge clk.
REQ-005 Port reset  in  1: asynchronous, active-low reset.
REQ-006 Ports recoverFlag_i, exceptionFlag_i, flagRecoverEX_i, flagRecoverID_i  in  1 each: redirect requests.
REQ-007 Ports recoverPC_i, exceptionPC_i, targetAddrEX_i, targetAddrID_i  in  SIZE_PC each: redirect targets.
REQ-008 Ports btbHit_i, prediction_i  in  FETCH_WIDTH each; ctrlType_i  in  2*FETCH_WIDTH; targetAddr_i  in  SIZE_PC*FETCH_WIDTH: per-lane predictor data for current PC.
REQ-009 Port rasTop_i  in  SIZE_PC: RAS top-of-stack.
REQ-010 Ports icacheMiss_i, refillDone_i  in  1: miss for current PC; refill complete.
REQ-011 Port fetchReady_i  in  1: next stage accepts the group.
REQ-012 Ports pc_o  out  SIZE_PC; fetchValid_o  out  1; laneValid_o  out  FETCH_WIDTH: current group.
REQ-013 Ports rasPush_o, rasPop_o  out  1; rasPushAddr_o  out  SIZE_PC: RAS control.
REQ-014 Ports missReq_o  out  1; missAddr_o  out  SIZE_PC: refill request.

Function
REQ-015 Lane k taken = btbHit_i[k] & (prediction_i[k] | ctrlType k != 2'b11); first taken lane = lowest k taken among enabled lanes.
REQ-016 laneValid_o: enabled lanes 0..first taken lane inclusive, all enabled lanes if none taken; all zero when fetchValid_o=0.
REQ-017 Next-PC priority: recoverFlag_i > exceptionFlag_i > flagRecoverEX_i > flagRecoverID_i > first taken lane > sequential.
REQ-018 Taken lane target: rasTop_i if ctrlType 2'b00 (return), else that lane's targetAddr_i.
REQ-019 Sequential next PC = PC + FETCH_WIDTH*INST_BYTES, modulo 2^SIZE_PC (wrap silently).
REQ-020 Advance = fetchValid_o & fetchReady_i; PC loads next PC on advance, one-cycle latency.
REQ-021 Any redirect loads its target next cycle regardless of stall, miss state or fetchReady_i.
REQ-022 fetchValid_o = (state RUN) & ~icacheMiss_i; PC held while fetchValid_o & ~fetchReady_i.
REQ-023 rasPush_o = advance & first taken lane k is call (2'b01) & no redirect; rasPushAddr_o = PC + (k+1)*INST_BYTES.
REQ-024 rasPop_o = advance & first taken lane is return (2'b00) & no redirect; push and pop mutually exclusive.
REQ-025 FSM states RUN, MISS, REPLAY; RUN->MISS when icacheMiss_i and no redirect.
REQ-026 On RUN->MISS, missReq_o pulses one cycle with missAddr_o = PC; PC held in MISS.
REQ-027 MISS->REPLAY on refillDone_i; REPLAY->RUN after exactly one cycle, fetchValid_o=0 in REPLAY.
REQ-028 Redirect in MISS or REPLAY: state->RUN, PC<=target, no further missReq_o for old PC; redirect wins over simultaneous refillDone_i.
REQ-029 icacheMiss_i in same cycle as redirect: miss ignored.

Reset
REQ-030 While reset low: PC=0, state RUN, fetchValid_o, laneValid_o, rasPush_o, rasPop_o, missReq_o all 0, rasPushAddr_o and missAddr_o 0.
REQ-031 Reset asserted mid-MISS aborts the miss; first cycle after release fetches PC 0.

Configuration
REQ-032 Macro FETCH_PC_ALIGN_EN defined: groups never cross a FETCH_WIDTH*INST_BYTES-aligned boundary; lanes below PC offset are disabled; sequential next PC = aligned base + block size.
REQ-033 Without FETCH_PC_ALIGN_EN: all FETCH_WIDTH lanes enabled for any PC; sequential next PC per REQ-019.

Structure
REQ-034 Shared package fetch_pkg holds the control-type encoding (00 return, 01 call, 10 jump, 11 conditional), FSM state typedef and INST_BYTES default.
REQ-035 One sub-module fetch_lane_select: combinational first-taken-lane finder producing lane index, found flag and lane mask.

Verification
REQ-036 Reset release, no hits, fetchReady_i=1, W=4 -> pc_o 0, 0x20, 0x40 on successive cycles.
REQ-037 PC=0x100, lane1 call hit, target 0x800 -> laneValid_o=4'b0011, rasPush_o=1, rasPushAddr_o=0x110, next pc_o=0x800.
REQ-038 PC=0x200, lane2 return hit, rasTop_i=0x1234 -> rasPop_o=1, next pc_o=0x1234; same stimulus with fetchReady_i=0 -> PC held, no pop.
REQ-039 icacheMiss_i at PC=0x300 -> one missReq_o with missAddr_o=0x300; refillDone_i -> one REPLAY cycle then fetchValid_o=1 at 0x300.
REQ-040 In MISS, flagRecoverEX_i with target 0x900 and refillDone_i same cycle -> next pc_o=0x900, state RUN, no missReq_o.
REQ-041 FETCH_PC_ALIGN_EN, PC=0x118, W=4 -> laneValid_o=4'b1000, next sequential pc_o=0x120.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch types: control-type encoding, fetch FSM states and the default lane stride.
package fetch_pkg;

    typedef enum logic [1:0] {
        CT_RETURN = 2'b00,
        CT_CALL   = 2'b01,
        CT_JUMP   = 2'b10,
        CT_COND   = 2'b11
    } ctrl_type_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MISS   = 2'b01,
        ST_REPLAY = 2'b10
    } fetch_state_e;

    localparam int INST_BYTES_DEF = 8;

    // Lane index needs at least one bit even for a single-lane build.
    function automatic int laneIdxWidth(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit signal bundle: redirects, predictor data, cache status, fetch group and RAS/refill outputs.
interface fetch_pc_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int SIZE_PC     = 32
);
    logic                           recoverFlag_i;
    logic                           exceptionFlag_i;
    logic                           flagRecoverEX_i;
    logic                           flagRecoverID_i;
    logic [SIZE_PC-1:0]             recoverPC_i;
    logic [SIZE_PC-1:0]             exceptionPC_i;
    logic [SIZE_PC-1:0]             targetAddrEX_i;
    logic [SIZE_PC-1:0]             targetAddrID_i;
    logic [FETCH_WIDTH-1:0]         btbHit_i;
    logic [FETCH_WIDTH-1:0]         prediction_i;
    logic [2*FETCH_WIDTH-1:0]       ctrlType_i;
    logic [SIZE_PC*FETCH_WIDTH-1:0] targetAddr_i;
    logic [SIZE_PC-1:0]             rasTop_i;
    logic                           icacheMiss_i;
    logic                           refillDone_i;
    logic                           fetchReady_i;
    logic [SIZE_PC-1:0]             pc_o;
    logic                           fetchValid_o;
    logic [FETCH_WIDTH-1:0]         laneValid_o;
    logic                           rasPush_o;
    logic                           rasPop_o;
    logic [SIZE_PC-1:0]             rasPushAddr_o;
    logic                           missReq_o;
    logic [SIZE_PC-1:0]             missAddr_o;

    // Environment side: drives redirects, predictor data and cache status.
    modport master (
        output recoverFlag_i, exceptionFlag_i, flagRecoverEX_i, flagRecoverID_i,
        output recoverPC_i, exceptionPC_i, targetAddrEX_i, targetAddrID_i,
        output btbHit_i, prediction_i, ctrlType_i, targetAddr_i, rasTop_i,
        output icacheMiss_i, refillDone_i, fetchReady_i,
        input  pc_o, fetchValid_o, laneValid_o,
        input  rasPush_o, rasPop_o, rasPushAddr_o, missReq_o, missAddr_o
    );

    // Fetch PC unit side.
    modport slave (
        input  recoverFlag_i, exceptionFlag_i, flagRecoverEX_i, flagRecoverID_i,
        input  recoverPC_i, exceptionPC_i, targetAddrEX_i, targetAddrID_i,
        input  btbHit_i, prediction_i, ctrlType_i, targetAddr_i, rasTop_i,
        input  icacheMiss_i, refillDone_i, fetchReady_i,
        output pc_o, fetchValid_o, laneValid_o,
        output rasPush_o, rasPop_o, rasPushAddr_o, missReq_o, missAddr_o
    );
endinterface

// File: rtl/fetch_lane_select.sv
// First-taken-lane finder: index and found flag of the lowest taken enabled lane, plus the valid-lane mask up to it.
module fetch_lane_select
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int IDX_W       = 2
) (
    input  logic [FETCH_WIDTH-1:0]   btbHit,
    input  logic [FETCH_WIDTH-1:0]   prediction,
    input  logic [2*FETCH_WIDTH-1:0] ctrlType,
    input  logic [FETCH_WIDTH-1:0]   laneEnable,
    output logic [IDX_W-1:0]         firstLane,
    output logic                     laneFound,
    output logic [FETCH_WIDTH-1:0]   laneMask
);
    always_comb begin
        firstLane = '0;
        laneFound = 1'b0;
        laneMask  = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (!laneFound) begin
                laneMask[k] = laneEnable[k];
                // Unconditional control flow is always taken; conditionals follow the predictor.
                if (laneEnable[k] && btbHit[k] &&
                    (prediction[k] || (ctrlType[2*k +: 2] != CT_COND))) begin
                    laneFound = 1'b1;
                    firstLane = IDX_W'(k);
                end
            end
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: next-PC selection, RAS push/pop control and I-cache miss/replay sequencing.
// Optional FETCH_PC_ALIGN_EN keeps each fetch group inside one aligned block.
//
// state     | meaning
// ST_RUN    | fetching; group valid unless the cache misses
// ST_MISS   | refill outstanding for pc, pc held
// ST_REPLAY | one dead cycle after refill before re-fetching pc
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int SIZE_PC     = 32,
    parameter int INST_BYTES  = INST_BYTES_DEF
) (
    input logic       clk,
    input logic       reset,
    fetch_pc_if.slave fpIf
);
    localparam int                 IDX_W       = laneIdxWidth(FETCH_WIDTH);
    localparam logic [SIZE_PC-1:0] BLOCK_BYTES = SIZE_PC'(FETCH_WIDTH * INST_BYTES);
    localparam logic [SIZE_PC-1:0] LANE_BYTES  = SIZE_PC'(INST_BYTES);

    fetch_state_e           state, stateNext;
    logic [SIZE_PC-1:0]     pc, pcNext;
    logic [SIZE_PC-1:0]     groupBase, redirectTarget, takenTarget, pushAddr;
    logic [FETCH_WIDTH-1:0] laneEnable, laneMask;
    logic [IDX_W-1:0]       firstLane;
    logic                   laneFound, redirect, fetchValid, advance, missReq;
    logic                   rasPush, rasPop;
    ctrl_type_e             takenType;

`ifdef FETCH_PC_ALIGN_EN
    logic [SIZE_PC-1:0] pcOffset;

    assign pcOffset  = pc % BLOCK_BYTES;
    assign groupBase = pc - pcOffset;

    always_comb begin
        laneEnable = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            laneEnable[k] = ((pcOffset / LANE_BYTES) <= SIZE_PC'(k));
    end
`else
    assign groupBase  = pc;
    assign laneEnable = '1;
`endif

    fetch_lane_select #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .IDX_W       (IDX_W)
    ) u_laneSelect (
        .btbHit     (fpIf.btbHit_i),
        .prediction (fpIf.prediction_i),
        .ctrlType   (fpIf.ctrlType_i),
        .laneEnable (laneEnable),
        .firstLane  (firstLane),
        .laneFound  (laneFound),
        .laneMask   (laneMask)
    );

    always_comb begin
        redirect       = 1'b1;
        redirectTarget = '0;
        if (fpIf.recoverFlag_i)        redirectTarget = fpIf.recoverPC_i;
        else if (fpIf.exceptionFlag_i) redirectTarget = fpIf.exceptionPC_i;
        else if (fpIf.flagRecoverEX_i) redirectTarget = fpIf.targetAddrEX_i;
        else if (fpIf.flagRecoverID_i) redirectTarget = fpIf.targetAddrID_i;
        else                           redirect       = 1'b0;
    end

    assign takenType   = ctrl_type_e'(fpIf.ctrlType_i[2*firstLane +: 2]);
    assign takenTarget = (takenType == CT_RETURN) ? fpIf.rasTop_i
                                                  : fpIf.targetAddr_i[SIZE_PC*firstLane +: SIZE_PC];
    // Lane addresses count from the group base, which equals pc unless groups are aligned.
    assign pushAddr    = groupBase + SIZE_PC'(int'(firstLane) + 1) * LANE_BYTES;

    // Reset gates the combinational outputs so nothing is presented while held in reset.
    assign fetchValid = reset & (state == ST_RUN) & ~fpIf.icacheMiss_i;
    assign advance    = fetchValid & fpIf.fetchReady_i;
    assign missReq    = reset & (state == ST_RUN) & fpIf.icacheMiss_i & ~redirect;
    assign rasPush    = advance & laneFound & ~redirect & (takenType == CT_CALL);
    assign rasPop     = advance & laneFound & ~redirect & (takenType == CT_RETURN);

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        case (state)
            ST_RUN:    if (fpIf.icacheMiss_i) stateNext = ST_MISS;
            ST_MISS:   if (fpIf.refillDone_i) stateNext = ST_REPLAY;
            ST_REPLAY: stateNext = ST_RUN;
            default:   stateNext = ST_RUN;
        endcase
        // A redirect overrides miss handling and stalls in every state.
        if (redirect) begin
            stateNext = ST_RUN;
            pcNext    = redirectTarget;
        end else if (advance) begin
            pcNext = laneFound ? takenTarget : groupBase + BLOCK_BYTES;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            pc    <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    assign fpIf.pc_o          = pc;
    assign fpIf.fetchValid_o  = fetchValid;
    assign fpIf.laneValid_o   = fetchValid ? laneMask : '0;
    assign fpIf.rasPush_o     = rasPush;
    assign fpIf.rasPop_o      = rasPop;
    assign fpIf.rasPushAddr_o = rasPush ? pushAddr : '0;
    assign fpIf.missReq_o     = missReq;
    assign fpIf.missAddr_o    = missReq ? pc : '0;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit (FETCH_WIDTH=4, SIZE_PC=32, INST_BYTES=8); FETCH_PC_ALIGN_EN selects aligned-group expectations.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;

    fetch_pc_if #(.FETCH_WIDTH(4), .SIZE_PC(32)) fpIf ();

    fetch_pc_unit #(
        .FETCH_WIDTH (4),
        .SIZE_PC     (32),
        .INST_BYTES  (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .fpIf  (fpIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        fpIf.recoverFlag_i   = 1'b0;
        fpIf.exceptionFlag_i = 1'b0;
        fpIf.flagRecoverEX_i = 1'b0;
        fpIf.flagRecoverID_i = 1'b0;
        fpIf.recoverPC_i     = '0;
        fpIf.exceptionPC_i   = '0;
        fpIf.targetAddrEX_i  = '0;
        fpIf.targetAddrID_i  = '0;
        fpIf.btbHit_i        = '0;
        fpIf.prediction_i    = '0;
        fpIf.ctrlType_i      = '0;
        fpIf.targetAddr_i    = '0;
        fpIf.rasTop_i        = '0;
        fpIf.icacheMiss_i    = 1'b0;
        fpIf.refillDone_i    = 1'b0;
        fpIf.fetchReady_i    = 1'b1;
    endtask

    task automatic redir(input logic [31:0] addr);
        fpIf.flagRecoverID_i = 1'b1;
        fpIf.targetAddrID_i  = addr;
        cyc();
        fpIf.flagRecoverID_i = 1'b0;
        fpIf.targetAddrID_i  = '0;
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        clearInputs();
        reset = 1'b0;
        fpIf.icacheMiss_i = 1'b1;
        cyc();
        cyc();
        chk("rst_pc", fpIf.pc_o, 32'h0);
        chk("rst_fetchValid", fpIf.fetchValid_o, 32'h0);
        chk("rst_laneValid", fpIf.laneValid_o, 32'h0);
        chk("rst_missReq", fpIf.missReq_o, 32'h0);
        chk("rst_missAddr", fpIf.missAddr_o, 32'h0);
        chk("rst_rasPush", fpIf.rasPush_o, 32'h0);
        fpIf.icacheMiss_i = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_pc", fpIf.pc_o, 32'h0);
        chk("rel_fetchValid", fpIf.fetchValid_o, 32'h1);
        chk("rel_laneValid", fpIf.laneValid_o, 32'hF);
        cyc();
        chk("seq_pc1", fpIf.pc_o, 32'h20);
        cyc();
        chk("seq_pc2", fpIf.pc_o, 32'h40);

        // Call on lane 1, later jump on lane 3 must be ignored.
        redir(32'h100);
        chk("redir_pc100", fpIf.pc_o, 32'h100);
        fpIf.btbHit_i = 4'b1010;
        fpIf.ctrlType_i[2*1 +: 2] = CT_CALL;
        fpIf.ctrlType_i[2*3 +: 2] = CT_JUMP;
        fpIf.targetAddr_i[32*1 +: 32] = 32'h800;
        fpIf.targetAddr_i[32*3 +: 32] = 32'hBAD0;
        #1;
        chk("call_laneValid", fpIf.laneValid_o, 32'h3);
        chk("call_rasPush", fpIf.rasPush_o, 32'h1);
        chk("call_pushAddr", fpIf.rasPushAddr_o, 32'h110);
        chk("call_rasPop", fpIf.rasPop_o, 32'h0);
        cyc();
        chk("call_nextPc", fpIf.pc_o, 32'h800);
        clearInputs();

        // Return on lane 2: stalled first, then accepted.
        fpIf.exceptionFlag_i = 1'b1;
        fpIf.exceptionPC_i   = 32'h200;
        cyc();
        clearInputs();
        fpIf.btbHit_i = 4'b0100;
        fpIf.ctrlType_i[2*2 +: 2] = CT_RETURN;
        fpIf.targetAddr_i[32*2 +: 32] = 32'hDEAD0;
        fpIf.rasTop_i = 32'h1234;
        fpIf.fetchReady_i = 1'b0;
        #1;
        chk("ret_stall_pc", fpIf.pc_o, 32'h200);
        chk("ret_stall_pop", fpIf.rasPop_o, 32'h0);
        chk("ret_laneValid", fpIf.laneValid_o, 32'h7);
        chk("ret_stall_valid", fpIf.fetchValid_o, 32'h1);
        cyc();
        chk("ret_held_pc", fpIf.pc_o, 32'h200);
        fpIf.fetchReady_i = 1'b1;
        #1;
        chk("ret_pop", fpIf.rasPop_o, 32'h1);
        chk("ret_push", fpIf.rasPush_o, 32'h0);
        cyc();
        chk("ret_nextPc", fpIf.pc_o, 32'h1234);
        clearInputs();

        // Conditional on lane 0: not predicted then predicted.
        fpIf.btbHit_i = 4'b0001;
        fpIf.ctrlType_i[1:0] = CT_COND;
        fpIf.targetAddr_i[31:0] = 32'h4000;
        #1;
        chk("cond_nt_laneValid", fpIf.laneValid_o, 32'hF);
        cyc();
        chk("cond_nt_pc", fpIf.pc_o, 32'h1254);
        fpIf.prediction_i = 4'b0001;
        #1;
        chk("cond_t_laneValid", fpIf.laneValid_o, 32'h1);
        cyc();
        chk("cond_t_pc", fpIf.pc_o, 32'h4000);
        clearInputs();

        // Redirect priority, with a call hit that must not push.
        fpIf.recoverFlag_i = 1'b1;   fpIf.recoverPC_i    = 32'hA00;
        fpIf.exceptionFlag_i = 1'b1; fpIf.exceptionPC_i  = 32'hB00;
        fpIf.flagRecoverEX_i = 1'b1; fpIf.targetAddrEX_i = 32'hC00;
        fpIf.flagRecoverID_i = 1'b1; fpIf.targetAddrID_i = 32'hD00;
        fpIf.btbHit_i = 4'b0001;
        fpIf.ctrlType_i[1:0] = CT_CALL;
        fpIf.targetAddr_i[31:0] = 32'h5000;
        #1;
        chk("prio_noPush", fpIf.rasPush_o, 32'h0);
        cyc();
        chk("prio_recover", fpIf.pc_o, 32'hA00);
        fpIf.recoverFlag_i = 1'b0;
        fpIf.exceptionFlag_i = 1'b0;
        cyc();
        chk("prio_ex_over_id", fpIf.pc_o, 32'hC00);
        clearInputs();

        // Miss, refill, replay.
        redir(32'h300);
        fpIf.icacheMiss_i = 1'b1;
        #1;
        chk("miss_req", fpIf.missReq_o, 32'h1);
        chk("miss_addr", fpIf.missAddr_o, 32'h300);
        chk("miss_valid", fpIf.fetchValid_o, 32'h0);
        chk("miss_laneValid", fpIf.laneValid_o, 32'h0);
        cyc();
        fpIf.icacheMiss_i = 1'b0;
        #1;
        chk("inmiss_req", fpIf.missReq_o, 32'h0);
        chk("inmiss_pc", fpIf.pc_o, 32'h300);
        chk("inmiss_valid", fpIf.fetchValid_o, 32'h0);
        cyc();
        chk("inmiss_req2", fpIf.missReq_o, 32'h0);
        fpIf.refillDone_i = 1'b1;
        cyc();
        fpIf.refillDone_i = 1'b0;
        #1;
        chk("replay_valid", fpIf.fetchValid_o, 32'h0);
        chk("replay_pc", fpIf.pc_o, 32'h300);
        cyc();
        chk("resume_valid", fpIf.fetchValid_o, 32'h1);
        chk("resume_pc", fpIf.pc_o, 32'h300);

        // Redirect in MISS beats refillDone.
        cyc();
        chk("adv_pc320", fpIf.pc_o, 32'h320);
        fpIf.icacheMiss_i = 1'b1;
        #1;
        chk("miss2_addr", fpIf.missAddr_o, 32'h320);
        cyc();
        fpIf.icacheMiss_i = 1'b0;
        fpIf.flagRecoverEX_i = 1'b1;
        fpIf.targetAddrEX_i = 32'h900;
        fpIf.refillDone_i = 1'b1;
        #1;
        chk("missredir_req", fpIf.missReq_o, 32'h0);
        cyc();
        clearInputs();
        #1;
        chk("missredir_pc", fpIf.pc_o, 32'h900);
        chk("missredir_valid", fpIf.fetchValid_o, 32'h1);
        chk("missredir_req2", fpIf.missReq_o, 32'h0);
        cyc();
        chk("missredir_adv", fpIf.pc_o, 32'h920);

        // Miss coinciding with a redirect is dropped.
        fpIf.icacheMiss_i = 1'b1;
        fpIf.flagRecoverID_i = 1'b1;
        fpIf.targetAddrID_i = 32'h118;
        #1;
        chk("missign_req", fpIf.missReq_o, 32'h0);
        cyc();
        clearInputs();
        #1;
        chk("missign_valid", fpIf.fetchValid_o, 32'h1);
        chk("missign_pc", fpIf.pc_o, 32'h118);

`ifdef FETCH_PC_ALIGN_EN
        chk("align_laneValid", fpIf.laneValid_o, 32'h8);
        cyc();
        chk("align_nextPc", fpIf.pc_o, 32'h120);
        redir(32'hFFFF_FFF0);
        chk("align_wrap_lanes", fpIf.laneValid_o, 32'hC);
        cyc();
        chk("align_wrap_pc", fpIf.pc_o, 32'h0);
`else
        chk("unal_laneValid", fpIf.laneValid_o, 32'hF);
        cyc();
        chk("unal_nextPc", fpIf.pc_o, 32'h138);
        redir(32'hFFFF_FFF0);
        chk("wrap_lanes", fpIf.laneValid_o, 32'hF);
        cyc();
        chk("wrap_pc", fpIf.pc_o, 32'h10);
`endif

        // Reset during MISS aborts the miss.
        redir(32'h700);
        fpIf.icacheMiss_i = 1'b1;
        cyc();
        fpIf.icacheMiss_i = 1'b0;
        #1;
        chk("rstmiss_inmiss", fpIf.fetchValid_o, 32'h0);
        reset = 1'b0;
        #1;
        chk("rstmiss_pc", fpIf.pc_o, 32'h0);
        chk("rstmiss_req", fpIf.missReq_o, 32'h0);
        cyc();
        reset = 1'b1;
        #1;
        chk("rstmiss_valid", fpIf.fetchValid_o, 32'h1);
        chk("rstmiss_pc0", fpIf.pc_o, 32'h0);
        cyc();
        chk("rstmiss_adv", fpIf.pc_o, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
